// File: rtl/fsm_processador_tx_if.sv
// Signal bundle between the processor, fsm_processador_tx and peripheral 1.
// The master side writes words and returns ack; the slave side is the transmitter.
interface fsm_processador_tx_if #(
  parameter int WIDTH = 8
);
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             err_clr;
  logic [1:0]       ack;
  logic             dado;
  logic             send;
  logic             full;
  logic             empty;
  logic             busy;
  logic             timeout_err;
  logic             ovf_err;
  logic [15:0]      words_sent;

  modport master (
    output wr_en, wr_data, err_clr, ack,
    input  dado, send, full, empty, busy, timeout_err, ovf_err, words_sent
  );

  modport slave (
    input  wr_en, wr_data, err_clr, ack,
    output dado, send, full, empty, busy, timeout_err, ovf_err, words_sent
  );
endinterface

// File: rtl/fsm_processador_tx.sv
// Word FIFO feeding a bit-serial four-phase send/ack transmitter, LSB first,
// with a stall watchdog and sticky timeout/overflow flags.
module fsm_processador_tx #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64
) (
  input logic                 clk,
  input logic                 rst,
  fsm_processador_tx_if.slave bus
);
  // state | meaning
  // IDLE  | no word in flight; pops the FIFO head when one is queued
  // REQ   | send=1 with the current bit on dado, waiting for ack==01
  // REL   | send=0, bit still on dado, waiting for ack==00

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BIT_W = $clog2(WIDTH);
  localparam int WD_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT > 0) ? WD_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  state_t           state;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] shreg;
  logic [BIT_W-1:0] bit_cnt;
  logic [WD_W-1:0]  wd_cnt;
  logic             send_q;
  logic             busy_q;
  logic             timeout_q;
  logic             ovf_q;
  logic [15:0]      words_sent_q;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic wd_hit;
  logic bit_last;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign push     = bus.wr_en && !full;
  assign pop      = (state == IDLE) && !empty;
  assign wd_hit   = (TIMEOUT != 0) && (wd_cnt == WD_LAST);
  assign bit_last = (bit_cnt == BIT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  // A write while full is dropped and flags overflow even if a pop frees a slot this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
      if (bus.err_clr)          ovf_q <= 1'b0;
      if (bus.wr_en && full)    ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      shreg        <= '0;
      bit_cnt      <= '0;
      wd_cnt       <= '0;
      send_q       <= 1'b0;
      busy_q       <= 1'b0;
      timeout_q    <= 1'b0;
      words_sent_q <= '0;
    end else begin
      if (bus.err_clr) timeout_q <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            shreg   <= mem[rd_ptr];
            bit_cnt <= '0;
            wd_cnt  <= '0;
            state   <= REQ;
            send_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        REQ: begin
          if (bus.ack == 2'b01) begin
            state  <= REL;
            send_q <= 1'b0;
            wd_cnt <= '0;
          end else if (wd_hit) begin
            state     <= IDLE;
            send_q    <= 1'b0;
            busy_q    <= 1'b0;
            wd_cnt    <= '0;
            timeout_q <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        REL: begin
          if (bus.ack == 2'b00) begin
            wd_cnt <= '0;
            if (bit_last) begin
              words_sent_q <= words_sent_q + 16'd1;
              state        <= IDLE;
              busy_q       <= 1'b0;
            end else begin
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
              state   <= REQ;
              send_q  <= 1'b1;
            end
          end else if (wd_hit) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            wd_cnt    <= '0;
            timeout_q <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          send_q <= 1'b0;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dado        = shreg[0];
  assign bus.send        = send_q;
  assign bus.busy        = busy_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.timeout_err = timeout_q;
  assign bus.ovf_err     = ovf_q;
  assign bus.words_sent  = words_sent_q;
endmodule

// File: tb/tb_fsm_processador_tx.sv
// Bench for fsm_processador_tx: random words go through a peripheral model and are
// compared against an expected-word queue; timing and flag behaviour use directed steps.
module tb_fsm_processador_tx;
  localparam int WIDTH   = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 64;
  localparam int LAG     = 0;
  localparam int STUCK   = 1;
  localparam int MANUAL  = 2;

  logic clk = 1'b0;
  logic rst;

  fsm_processador_tx_if #(.WIDTH(WIDTH)) bus ();

  fsm_processador_tx #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_fail   = 0;
  int         pmode    = LAG;
  logic [1:0] ack_manual = 2'b00;

  // Peripheral: LAG echoes send one cycle late, STUCK never acks, MANUAL replays ack_manual.
  always @(posedge clk or posedge rst) begin
    if (rst) bus.ack <= 2'b00;
    else begin
      case (pmode)
        LAG:     bus.ack <= {1'b0, bus.send};
        MANUAL:  bus.ack <= ack_manual;
        default: bus.ack <= 2'b00;
      endcase
    end
  end

  logic [WIDTH-1:0] obs_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] cur = '0;
  int   bit_idx    = 0;
  int   send_rises = 0;
  int   stab_viol  = 0;
  logic prev_send  = 1'b0;
  logic prev_busy  = 1'b0;
  logic prev_dado  = 1'b0;

  // Rebuild words from the bit captured at each send rise; an abort or reset drops the partial word.
  always @(negedge clk) begin
    if (bus.busy && prev_busy && (bus.dado !== prev_dado) && !(bus.send && !prev_send))
      stab_viol++;
    if (!bus.busy) bit_idx = 0;
    else if (bus.send && !prev_send) begin
      send_rises++;
      cur[bit_idx] = bus.dado;
      bit_idx++;
      if (bit_idx == WIDTH) begin
        obs_q.push_back(cur);
        bit_idx = 0;
      end
    end
    prev_send = bus.send;
    prev_busy = bus.busy;
    prev_dado = bus.dado;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] w);
    bus.wr_en   = 1'b1;
    bus.wr_data = w;
    @(posedge clk);
    #1;
    bus.wr_en   = 1'b0;
  endtask

  task automatic pulse_clr();
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
  endtask

  task automatic wait_words(input int target, input int budget, input string tag);
    int g = 0;
    while (bus.words_sent != 16'(target) && g < budget) begin
      tick(1);
      g++;
    end
    check(tag, bus.words_sent, target);
  endtask

  task automatic check_word(input string tag);
    logic [31:0] o;
    logic [31:0] e;
    e = (exp_q.size() != 0) ? {24'b0, exp_q.pop_front()} : 32'hBAD0_0000;
    o = (obs_q.size() != 0) ? {24'b0, obs_q.pop_front()} : 32'hDEAD_BEEF;
    check(tag, o, e);
  endtask

  logic [WIDTH-1:0] w;
  int cyc, g, hi, ws0, rises0;
  logic seen;

  initial begin
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.err_clr = 1'b0;
    rst = 1'b1;
    #12;
    check("rst_send", bus.send, 0);
    check("rst_dado", bus.dado, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_full", bus.full, 0);
    check("rst_empty", bus.empty, 1);
    check("rst_timeout_err", bus.timeout_err, 0);
    check("rst_ovf_err", bus.ovf_err, 0);
    check("rst_words_sent", bus.words_sent, 0);
    @(negedge clk);
    rst = 1'b0;
    tick(1);

    // Single word A5: bit order, pulse count and 33-cycle word time.
    rises0 = send_rises;
    push(8'hA5);
    exp_q.push_back(8'hA5);
    cyc = 0;
    seen = 1'b0;
    while (cyc < 200 && !(seen && !bus.busy)) begin
      tick(1);
      cyc++;
      if (bus.busy) seen = 1'b1;
    end
    check("t1_word_cycles", cyc, 33);
    check("t1_words_sent", bus.words_sent, 1);
    check("t1_busy_after", bus.busy, 0);
    check("t1_send_pulses", send_rises - rises0, WIDTH);
    check_word("t1_word_a5");

    // Fill the FIFO behind an in-flight word, then overflow it.
    w = 8'($urandom);
    push(w);
    exp_q.push_back(w);
    tick(1);
    for (int i = 0; i < DEPTH; i++) begin
      w = 8'($urandom);
      push(w);
      exp_q.push_back(w);
    end
    check("t2_full", bus.full, 1);
    check("t2_ovf_before", bus.ovf_err, 0);
    push(8'($urandom));
    check("t2_ovf_set", bus.ovf_err, 1);
    check("t2_still_full", bus.full, 1);
    wait_words(6, 400, "t2_words_sent");
    for (int i = 0; i < DEPTH + 1; i++) check_word("t2_word_order");
    check("t2_empty_end", bus.empty, 1);

    // Stalled REQ aborts after TIMEOUT cycles; the queued word then goes out.
    ws0 = 6;
    pmode = STUCK;
    push(8'($urandom));
    w = 8'($urandom);
    push(w);
    exp_q.push_back(w);
    hi = 0;
    g = 0;
    while ((bus.send || hi == 0) && g < 200) begin
      if (bus.send) hi++;
      tick(1);
      g++;
    end
    pmode = LAG;
    check("t3_req_cycles", hi, TIMEOUT);
    check("t3_timeout_err", bus.timeout_err, 1);
    check("t3_words_unchanged", bus.words_sent, ws0);
    check("t3_busy_abort", bus.busy, 0);
    wait_words(ws0 + 1, 100, "t3_next_word_sent");
    check_word("t3_next_word");
    pulse_clr();
    check("t3_clr_timeout", bus.timeout_err, 0);
    check("t3_clr_ovf", bus.ovf_err, 0);

    // Non-01 acks hold REQ; non-00 acks hold REL.
    ws0 = ws0 + 1;
    pmode = MANUAL;
    ack_manual = 2'b00;
    w = 8'($urandom);
    push(w);
    exp_q.push_back(w);
    g = 0;
    while (!bus.send && g < 10) begin tick(1); g++; end
    check("t5_send_up", bus.send, 1);
    ack_manual = 2'b11;
    tick(6);
    check("t5_ack11_holds_req", bus.send, 1);
    ack_manual = 2'b01;
    g = 0;
    while (bus.send && g < 10) begin tick(1); g++; end
    check("t5_rel_on_01", bus.send, 0);
    tick(6);
    check("t5_hold01_no_next", bus.send, 0);
    check("t5_hold01_busy", bus.busy, 1);
    ack_manual = 2'b10;
    tick(3);
    check("t5_ack10_holds_rel", bus.send, 0);
    ack_manual = 2'b00;
    g = 0;
    while (!bus.send && g < 10) begin tick(1); g++; end
    check("t5_next_bit", bus.send, 1);
    pmode = LAG;
    wait_words(ws0 + 1, 100, "t5_words_sent");
    check_word("t5_word");

    // Push in the same cycle as the IDLE pop; overflow racing err_clr.
    ws0 = ws0 + 1;
    for (int i = 0; i < 2; i++) begin
      w = 8'($urandom);
      push(w);
      exp_q.push_back(w);
    end
    g = 0;
    while (bus.busy && g < 100) begin tick(1); g++; end
    check("t6_idle_gap", bus.busy, 0);
    w = 8'($urandom);
    push(w);
    exp_q.push_back(w);
    check("t6_push_pop_not_empty", bus.empty, 0);
    for (int i = 0; i < 3; i++) begin
      check("t6_full_before_fill", bus.full, 0);
      w = 8'($urandom);
      push(w);
      exp_q.push_back(w);
    end
    check("t6_full_after_fill", bus.full, 1);
    check("t6_ovf_pre", bus.ovf_err, 0);
    push(8'($urandom));
    check("t6_ovf_set", bus.ovf_err, 1);
    bus.err_clr = 1'b1;
    push(8'($urandom));
    bus.err_clr = 1'b0;
    check("t6_ovf_set_beats_clr", bus.ovf_err, 1);
    pulse_clr();
    check("t6_ovf_cleared", bus.ovf_err, 0);
    wait_words(ws0 + 6, 400, "t6_words_sent");
    for (int i = 0; i < 6; i++) check_word("t6_word_order");

    // Asynchronous reset in the middle of bit 3.
    rises0 = send_rises;
    for (int i = 0; i < 3; i++) push(8'($urandom));
    g = 0;
    while (send_rises - rises0 < 4 && g < 100) begin tick(1); g++; end
    check("t4_reached_bit3", send_rises - rises0, 4);
    rst = 1'b1;
    #1;
    check("t4_async_send", bus.send, 0);
    check("t4_async_empty", bus.empty, 1);
    check("t4_async_words", bus.words_sent, 0);
    check("t4_async_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    obs_q.delete();
    tick(1);
    for (int i = 0; i < 2; i++) begin
      w = 8'($urandom);
      push(w);
      exp_q.push_back(w);
    end
    wait_words(2, 200, "t4_words_after_reset");
    for (int i = 0; i < 2; i++) check_word("t4_word_after_reset");

    check("dado_stability", stab_viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
